// File: rtl/ucie_ctl_phy_pkg.sv
// Shared constants for the UCIe PHY sideband receive path.
// Defaults here are the widths/depths the controller integrates with.
package ucie_ctl_phy_pkg;

    localparam int UCIE_SB_NC    = 32;
    localparam int UCIE_SB_DEPTH = 4;
    localparam int UCIE_SB_CRD   = 4;

    // Credit count is carried on a fixed 4-bit field toward the adapter.
    localparam int UCIE_CRD_W    = 4;

endpackage : ucie_ctl_phy_pkg

// File: rtl/ucie_ctl_sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through read port.
// Pointers wrap naturally because DEPTH is a power of two.
module ucie_ctl_sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          wr_en;
    logic          rd_en;

    // A write on full is only legal when the same cycle frees a slot.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // NOTE: storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;

endmodule : ucie_ctl_sync_fifo

// File: rtl/ucie_ctl_phy_sb_msg_rx_buf.sv
// Sideband message receive buffer: queues incoming words and releases them to the
// adapter's RDI config interface under a credit count owned by the PHY.
module ucie_ctl_phy_sb_msg_rx_buf
    import ucie_ctl_phy_pkg::*;
#(
    parameter int NC    = UCIE_SB_NC,
    parameter int DEPTH = UCIE_SB_DEPTH,
    parameter int CRD   = UCIE_SB_CRD
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_sb_data_valid,
    input  logic [NC-1:0]            i_data_received_sb,
    input  logic                     i_rdi_lp_cfg_crd,
    output logic                     o_rdi_pl_cfg_vld,
    output logic [NC-1:0]            o_rdi_pl_cfg,
    output logic [UCIE_CRD_W-1:0]    o_crd_avail,
    output logic [$clog2(DEPTH):0]   o_fifo_level,
    output logic                     o_ovf_err,
    output logic                     o_crd_err
);

    localparam logic [UCIE_CRD_W-1:0] CRD_INIT = UCIE_CRD_W'(CRD);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [NC-1:0]         fifo_data;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [UCIE_CRD_W-1:0] crd_q;
    logic [UCIE_CRD_W-1:0] crd_d;
    logic                  crd_ovr;
    logic                  vld_q;
    logic [NC-1:0]         data_q;
    logic                  ovf_q;
    logic                  crd_err_q;

    // A pop needs both a buffered word and a credit, so crd never underflows.
    assign pop  = !fifo_empty && (crd_q != '0);
    assign push = i_sb_data_valid && (!fifo_full || pop);
    assign drop = i_sb_data_valid && fifo_full && !pop;

    ucie_ctl_sync_fifo #(
        .W     (NC),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .push      (push),
        .push_data (i_data_received_sb),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (o_fifo_level)
    );

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        crd_d   = crd_q;
        crd_ovr = 1'b0;
        case ({pop, i_rdi_lp_cfg_crd})
            2'b10: crd_d = crd_q - UCIE_CRD_W'(1);
            2'b01: begin
                if (crd_q == CRD_INIT) crd_ovr = 1'b1;
                else                   crd_d   = crd_q + UCIE_CRD_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            crd_q     <= CRD_INIT;
            vld_q     <= 1'b0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            crd_err_q <= 1'b0;
        end else begin
            crd_q     <= crd_d;
            vld_q     <= pop;
            data_q    <= pop ? fifo_data : '0;
            ovf_q     <= ovf_q | drop;
            crd_err_q <= crd_err_q | crd_ovr;
        end
    end

    assign o_rdi_pl_cfg_vld = vld_q;
    assign o_rdi_pl_cfg     = data_q;
    assign o_crd_avail      = crd_q;
    assign o_ovf_err        = ovf_q;
    assign o_crd_err        = crd_err_q;

endmodule : ucie_ctl_phy_sb_msg_rx_buf

// File: tb/tb_ucie_ctl_phy_sb_msg_rx_buf.sv
// Directed bench for the sideband receive buffer: default instance plus two
// parameter variants (NC=8/DEPTH=2 and NC=64/DEPTH=8).
module tb_ucie_ctl_phy_sb_msg_rx_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld_in = 1'b0;
    logic [31:0] din = '0;
    logic        crd_in = 1'b0;
    logic        vld_out;
    logic [31:0] dout;
    logic [3:0]  crd;
    logic [2:0]  level;
    logic        ovf;
    logic        crd_err;

    logic        s_vld = 1'b0;
    logic [63:0] s_din = '0;
    logic        s_crd = 1'b0;
    logic        a_vld, a_ovf, a_crd_err;
    logic [7:0]  a_dout;
    logic [3:0]  a_crd;
    logic [1:0]  a_level;
    logic        b_vld, b_ovf, b_crd_err;
    logic [63:0] b_dout;
    logic [3:0]  b_crd;
    logic [3:0]  b_level;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ucie_ctl_phy_sb_msg_rx_buf dut (
        .i_clk (clk), .i_rst_n (rst_n), .i_sb_data_valid (vld_in),
        .i_data_received_sb (din), .i_rdi_lp_cfg_crd (crd_in),
        .o_rdi_pl_cfg_vld (vld_out), .o_rdi_pl_cfg (dout), .o_crd_avail (crd),
        .o_fifo_level (level), .o_ovf_err (ovf), .o_crd_err (crd_err)
    );

    ucie_ctl_phy_sb_msg_rx_buf #(.NC(8), .DEPTH(2)) dut_a (
        .i_clk (clk), .i_rst_n (rst_n), .i_sb_data_valid (s_vld),
        .i_data_received_sb (s_din[7:0]), .i_rdi_lp_cfg_crd (s_crd),
        .o_rdi_pl_cfg_vld (a_vld), .o_rdi_pl_cfg (a_dout), .o_crd_avail (a_crd),
        .o_fifo_level (a_level), .o_ovf_err (a_ovf), .o_crd_err (a_crd_err)
    );

    ucie_ctl_phy_sb_msg_rx_buf #(.NC(64), .DEPTH(8)) dut_b (
        .i_clk (clk), .i_rst_n (rst_n), .i_sb_data_valid (s_vld),
        .i_data_received_sb (s_din), .i_rdi_lp_cfg_crd (s_crd),
        .o_rdi_pl_cfg_vld (b_vld), .o_rdi_pl_cfg (b_dout), .o_crd_avail (b_crd),
        .o_fifo_level (b_level), .o_ovf_err (b_ovf), .o_crd_err (b_crd_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_vld", vld_out, 0);
        chk("rst_data", dout, 0);
        chk("rst_crd", crd, 4);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_crd_err", crd_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single word: out two cycles after push, one cycle wide
        vld_in = 1'b1; din = 32'hA5A5_0001;
        tick();
        vld_in = 1'b0;
        chk("single_vld_c1", vld_out, 0);
        chk("single_level_c1", level, 1);
        tick();
        chk("single_vld_c2", vld_out, 1);
        chk("single_data_c2", dout, 32'hA5A5_0001);
        chk("single_crd", crd, 3);
        tick();
        chk("single_vld_c3", vld_out, 0);
        chk("single_data_c3", dout, 0);
        crd_in = 1'b1;
        tick();
        crd_in = 1'b0;
        chk("refill_crd", crd, 4);
        chk("refill_crd_err", crd_err, 0);

        // Credit exhaustion: six words, four credits
        for (int i = 0; i < 6; i++) begin
            vld_in = 1'b1; din = 32'h1000_0000 + 32'(i);
            tick();
            if (i >= 1 && i <= 4) begin
                chk("exh_vld", vld_out, 1);
                chk("exh_data", dout, 32'h1000_0000 + 32'(i - 1));
            end else begin
                chk("exh_idle", vld_out, 0);
            end
        end
        vld_in = 1'b0;
        chk("exh_level", level, 2);
        chk("exh_crd", crd, 0);
        tick();
        chk("exh_hold", vld_out, 0);
        crd_in = 1'b1;
        tick();
        crd_in = 1'b0;
        chk("exh_ret_crd", crd, 1);
        chk("exh_ret_vld", vld_out, 0);
        tick();
        chk("exh_w4_vld", vld_out, 1);
        chk("exh_w4_data", dout, 32'h1000_0004);
        chk("exh_w4_crd", crd, 0);
        chk("exh_w4_level", level, 1);

        // Drain the last word, then overflow with credits at zero
        crd_in = 1'b1;
        tick();
        crd_in = 1'b0;
        tick();
        chk("drain_data", dout, 32'h1000_0005);
        chk("drain_level", level, 0);
        for (int i = 0; i < 5; i++) begin
            vld_in = 1'b1; din = 32'hBEEF_0000 + 32'(i);
            tick();
            chk("ovf_level", level, (i < 4) ? i + 1 : 4);
            chk("ovf_flag", ovf, (i == 4) ? 1 : 0);
        end
        vld_in = 1'b0;
        chk("ovf_no_vld", vld_out, 0);

        // Credits one per cycle: pop with a return keeps crd steady
        crd_in = 1'b1;
        tick();
        chk("ovf_ret_crd", crd, 1);
        chk("ovf_ret_vld", vld_out, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ovf_out_vld", vld_out, 1);
            chk("ovf_out_data", dout, 32'hBEEF_0000 + 32'(i));
            chk("popret_crd", crd, 1);
        end
        crd_in = 1'b0;
        tick();
        chk("ovf_last_data", dout, 32'hBEEF_0003);
        chk("ovf_last_crd", crd, 0);
        chk("ovf_last_level", level, 0);
        tick();
        chk("ovf_w5_dropped", vld_out, 0);
        chk("ovf_w5_data", dout, 0);
        chk("ovf_sticky", ovf, 1);

        // Mid-stream reset with three words buffered
        for (int i = 0; i < 3; i++) begin
            vld_in = 1'b1; din = 32'hDEAD_0000 + 32'(i);
            tick();
        end
        vld_in = 1'b0;
        chk("mid_level_pre", level, 3);
        rst_n = 1'b0;
        #2;
        chk("mid_level", level, 0);
        chk("mid_crd", crd, 4);
        chk("mid_ovf", ovf, 0);
        chk("mid_vld", vld_out, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_vld", vld_out, 0);
        end
        chk("post_rst_level", level, 0);

        // Credit returned at full count
        crd_in = 1'b1;
        tick();
        crd_in = 1'b0;
        chk("crderr_crd", crd, 4);
        chk("crderr_flag", crd_err, 1);

        // Fill to full with credits exhausted, then push-on-full with a pop
        for (int i = 0; i < 8; i++) begin
            vld_in = 1'b1; din = 32'h5A00_0000 + 32'(i);
            tick();
        end
        vld_in = 1'b0;
        chk("full_level", level, 4);
        chk("full_crd", crd, 0);
        chk("full_ovf", ovf, 0);
        crd_in = 1'b1;
        tick();
        crd_in = 1'b0;
        chk("full_ret_crd", crd, 1);
        vld_in = 1'b1; din = 32'h6000_0001;
        tick();
        vld_in = 1'b0;
        chk("pushpop_level", level, 4);
        chk("pushpop_ovf", ovf, 0);
        chk("pushpop_vld", vld_out, 1);
        chk("pushpop_data", dout, 32'h5A00_0004);
        chk("pushpop_crd", crd, 0);
        chk("crderr_sticky", crd_err, 1);

        // Parameter variants: ten words back-to-back
        for (int i = 0; i < 10; i++) begin
            s_vld = 1'b1;
            s_din = {32'hC0DE_0000 + 32'(i), 32'h0000_00F0 + 32'(i)};
            tick();
        end
        s_vld = 1'b0;
        chk("a_level", a_level, 2);
        chk("a_ovf", a_ovf, 1);
        chk("a_crd", a_crd, 0);
        chk("b_level", b_level, 6);
        chk("b_ovf", b_ovf, 0);
        chk("b_crd", b_crd, 0);
        s_crd = 1'b1;
        tick();
        s_crd = 1'b0;
        tick();
        chk("a_vld", a_vld, 1);
        chk("a_data", a_dout, 8'hF4);
        chk("b_vld", b_vld, 1);
        chk("b_data", b_dout, 64'hC0DE_0004_0000_00F4);
        chk("a_crd_err", a_crd_err, 0);
        chk("b_crd_err", b_crd_err, 0);

        // Sticky flags clear only on reset
        rst_n = 1'b0;
        #2;
        chk("final_crd_err", crd_err, 0);
        chk("final_ovf", ovf, 0);
        chk("final_a_ovf", a_ovf, 0);
        chk("final_level", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ucie_ctl_phy_sb_msg_rx_buf

// File: doc/ucie_ctl_phy_sb_msg_rx_buf.md
UCIE_CTL_PHY_SB_MSG_RX_BUF -- requirements
Module: ucie_ctl_phy_sb_msg_rx_buf

Interface
REQ-001 Parameter NC, default 32: sideband word width in bits.
REQ-002 Parameter DEPTH, default 4: buffer depth in words, power of two, minimum 2.
REQ-003 Parameter CRD, default 4: RDI config credits owned by the PHY at reset, 1..15.
REQ-004 The clock and reset SHALL be i_clk and i_rst_n: reset i_rst_n, asynchronous, active-low; clock i_clk.
REQ-005 i_clk  input  1  block clock.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_sb_data_valid  input  1  sideband word present this cycle.
REQ-008 i_data_received_sb  input  NC  sideband word.
REQ-009 i_rdi_lp_cfg_crd  input  1  adapter returns one credit, single-cycle pulse.
REQ-010 o_rdi_pl_cfg_vld  output  1  one-cycle valid per word delivered to the adapter.
REQ-011 o_rdi_pl_cfg  output  NC  delivered word; all zeros whenever o_rdi_pl_cfg_vld is low.
REQ-012 o_crd_avail  output  4  current credit count.
REQ-013 o_fifo_level  output  $clog2(DEPTH)+1  words held in the buffer.
REQ-014 o_ovf_err  output  1  sticky: a word was dropped because the buffer was full.
REQ-015 o_crd_err  output  1  sticky: a credit was returned while the count was already CRD.

Function
REQ-016 Push: a cycle with i_sb_data_valid=1 SHALL write i_data_received_sb into the FIFO when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
REQ-017 Push on full without a same-cycle pop SHALL drop the word, leave the FIFO unchanged, and set o_ovf_err.
REQ-018 Pop: a word SHALL pop when level>0 and crd>0; at most one pop per cycle.
REQ-019 Output register: a pop SHALL load o_rdi_pl_cfg and set o_rdi_pl_cfg_vld=1 for exactly the next cycle; otherwise vld=0 and data=0.
REQ-020 Latency: a word pushed at edge k SHALL appear on the output in the cycle after edge k+1 when a credit is available (2 cycles); words SHALL leave in arrival order.
REQ-021 Back-to-back words with credits available SHALL produce back-to-back vld cycles, one word per cycle.
REQ-022 Credit counter: a pop decrements it; i_rdi_lp_cfg_crd increments it; both in the same cycle leave it unchanged.
REQ-023 A credit returned at count CRD with no same-cycle pop SHALL be ignored and set o_crd_err; the count never exceeds CRD and never goes below 0.
REQ-024 With crd==0, words SHALL be held in the FIFO; a credit returned at edge j allows a pop at edge j+1.
REQ-025 o_fifo_level SHALL equal pushes minus pops, saturating at 0..DEPTH; read and write pointers wrap modulo DEPTH.
REQ-026 o_ovf_err and o_crd_err SHALL clear only on reset.

Reset
REQ-027 While reset is asserted: o_rdi_pl_cfg_vld=0, o_rdi_pl_cfg=0, o_crd_avail=CRD, o_fifo_level=0, o_ovf_err=0, o_crd_err=0, and both pointers=0.
REQ-028 Reset asserted mid-stream SHALL discard buffered words and any word in flight; no vld pulse follows deassertion until a new push occurs.

Structure
REQ-029 Package ucie_ctl_phy_pkg SHALL hold the default constants UCIE_SB_NC=32, UCIE_SB_DEPTH=4 and UCIE_SB_CRD=4.
REQ-030 Buffer storage SHALL be a sub-module ucie_ctl_sync_fifo (parameters W and DEPTH; push/pop/full/empty/level); credit and output logic SHALL stay in the top module.

Verification
REQ-031 Single word: push 0xA5A5_0001 at cycle 0 -> vld=1 with 0xA5A5_0001 in cycle 2 only; crd goes 4->3.
REQ-032 Credit exhaustion: push 6 words back-to-back with no credit returns -> 4 words out in consecutive cycles, crd=0, level=2; one crd pulse -> 5th word out 2 cycles later.
REQ-033 Overflow: CRD held at 0 after exhaustion, push 5 words into an empty FIFO (DEPTH=4) -> level=4, o_ovf_err=1, 5th word never delivered.
REQ-034 Simultaneous events: pop together with a crd pulse -> crd unchanged; push on full together with a pop -> level stays 4, o_ovf_err stays 0.
REQ-035 Credit error: crd pulse at count 4 -> count stays 4, o_crd_err=1 until reset.
REQ-036 Mid-stream reset: 3 words buffered, assert i_rst_n low for 1 cycle -> level=0, crd=4, no vld afterwards; parameter sweep NC=8/64, DEPTH=2/8.
